// File: rtl/tt_um_example_vga_game.sv
// tt_um_example_vga_game: 640x480@60 scrolling VGA mini-game on the TinyVGA pinout.
// Build macro COLLISION_EN adds sticky player collision with freeze and restart.

module vga_game_sync (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       frame_tick
);
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_LAST       = 10'd524;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos <= '0;
            vpos <= '0;
        end else if (hpos == H_LAST) begin
            hpos <= '0;
            vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end else begin
            hpos <= hpos + 10'd1;
        end
    end

    // Sync outputs are active low.
    assign hsync      = !((hpos >= H_SYNC_START) && (hpos < H_SYNC_END));
    assign vsync      = !((vpos >= V_SYNC_START) && (vpos < V_SYNC_END));
    assign visible    = (hpos < H_VISIBLE) && (vpos < V_VISIBLE);
    assign frame_tick = (hpos == 10'd0) && (vpos == V_VISIBLE);
endmodule

module vga_game_top_line (
    input  logic [9:0] pix_y,
    output logic       on
);
    assign on = (pix_y < 10'd8);
endmodule

module vga_game_player #(
    parameter int PLAYER_X = 80,
    parameter int SPEED    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       down,
    input  logic       hold,
    input  logic       restart,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       on
);
    localparam logic [9:0] X0      = 10'(PLAYER_X);
    localparam logic [9:0] STEP    = 10'(SPEED);
    localparam logic [9:0] SIZE    = 10'd16;
    localparam logic [9:0] Y_MIN   = 10'd16;
    localparam logic [9:0] Y_MAX   = 10'd464;
    localparam logic [9:0] Y_START = 10'd232;

    logic [9:0] y_pos_reg;
    logic [9:0] y_pos_next;

    always_comb begin
        y_pos_next = y_pos_reg;
        if (restart) begin
            y_pos_next = Y_START;
        end else if (!hold) begin
            if (up && !down)
                y_pos_next = (y_pos_reg < Y_MIN + STEP) ? Y_MIN : y_pos_reg - STEP;
            else if (down && !up)
                y_pos_next = (y_pos_reg + STEP > Y_MAX) ? Y_MAX : y_pos_reg + STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            y_pos_reg <= Y_START;
        else if (frame_tick)
            y_pos_reg <= y_pos_next;
    end

    assign on = (pix_x >= X0) && (pix_x < X0 + SIZE) &&
                (pix_y >= y_pos_reg) && (pix_y < y_pos_reg + SIZE);
endmodule

module vga_game_u_shape (
    input  logic [9:0] x_offset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       on
);
    localparam logic [9:0] Y_TOP   = 10'd300;
    localparam logic [9:0] Y_BASE  = 10'd340;
    localparam logic [9:0] Y_END   = 10'd348;
    localparam logic [9:0] ARM_W   = 10'd8;
    localparam logic [9:0] RIGHT_X = 10'd32;
    localparam logic [9:0] WIDTH   = 10'd40;

    logic [9:0] x_pos;
    logic [9:0] dx;
    logic       in_arm_rows;
    logic       in_base_rows;

    // Anchor (600 - x_offset) mod 640; dx is the pixel's distance right of it, mod 640.
    always_comb begin
        x_pos = 10'd600 - x_offset;
        if (x_offset > 10'd600)
            x_pos = 10'd600 - x_offset + 10'd640;
        dx = pix_x - x_pos;
        if (pix_x < x_pos)
            dx = pix_x - x_pos + 10'd640;
    end

    assign in_arm_rows  = (pix_y >= Y_TOP) && (pix_y < Y_END);
    assign in_base_rows = (pix_y >= Y_BASE) && (pix_y < Y_END);
    assign on = (in_arm_rows && ((dx < ARM_W) || ((dx >= RIGHT_X) && (dx < WIDTH)))) ||
                (in_base_rows && (dx < WIDTH));
endmodule

module vga_game_sine_lut (
    input  logic [3:0] pos,
    output logic [7:0] value
);
    always_comb begin
        value = 8'd128;
        case (pos)
            4'd0:  value = 8'd128;
            4'd1:  value = 8'd177;
            4'd2:  value = 8'd218;
            4'd3:  value = 8'd245;
            4'd4:  value = 8'd255;
            4'd5:  value = 8'd245;
            4'd6:  value = 8'd218;
            4'd7:  value = 8'd177;
            4'd8:  value = 8'd128;
            4'd9:  value = 8'd79;
            4'd10: value = 8'd38;
            4'd11: value = 8'd11;
            4'd12: value = 8'd0;
            4'd13: value = 8'd11;
            4'd14: value = 8'd38;
            4'd15: value = 8'd79;
        endcase
    end
endmodule

module vga_game_double_sine #(
    parameter int TOP_X         = 100,
    parameter int TOP_Y         = 180,
    parameter int BOTTOM_X      = 540,
    parameter int BOTTOM_Y      = 400,
    parameter int BAR_WIDTH     = 40,
    parameter int VISIBLE_WIDTH = 25,
    parameter int HEIGHT        = 60
) (
    input  logic [9:0] x_offset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       on
);
    localparam logic [9:0] TX = 10'(TOP_X);
    localparam logic [9:0] TY = 10'(TOP_Y);
    localparam logic [9:0] BX = 10'(BOTTOM_X);
    localparam logic [9:0] BY = 10'(BOTTOM_Y);
    localparam logic [9:0] VW = 10'(VISIBLE_WIDTH);
    localparam logic [9:0] BAR_H = 10'd8;

    logic [10:0] u_sum;
    logic [9:0]  u;
    logic [14:0] ge;
    logic [3:0]  bar;
    logic [9:0]  phase;
    logic [7:0]  lut_value;
    logic [9:0]  s;
    logic        in_window;
    logic        upper_on;
    logic        lower_on;

    assign u_sum = {1'b0, pix_x} + {1'b0, x_offset} - 11'(TOP_X);
    assign u     = (u_sum >= 11'd640) ? 10'(u_sum - 11'd640) : u_sum[9:0];

    // Bar index = number of bar boundaries at or below u (u < 640 keeps it under 16).
    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_bar
            assign ge[gi-1] = (u >= 10'(gi * BAR_WIDTH));
        end
    endgenerate

    always_comb begin
        bar = '0;
        for (int i = 0; i < 15; i++)
            bar = bar + 4'(ge[i]);
    end

    assign phase = u - 10'(bar) * 10'(BAR_WIDTH);

    vga_game_sine_lut u_lut (
        .pos   (bar),
        .value (lut_value)
    );

    assign s = 10'((16'(lut_value) * 16'(HEIGHT)) >> 8);

    assign in_window = (pix_x >= TX) && (pix_x < BX);
    assign upper_on  = (pix_y >= TY + s) && (pix_y < TY + s + BAR_H);
    // Lower bar written with s moved across the compare to avoid underflow.
    assign lower_on  = (pix_y + s + BAR_H >= BY) && (pix_y + s < BY);
    assign on = in_window && (phase < VW) && (upper_on || lower_on);
endmodule

module tt_um_example_vga_game #(
    parameter int PLAYER_X      = 80,
    parameter int SPEED         = 2,
    parameter int TOP_X         = 100,
    parameter int TOP_Y         = 180,
    parameter int BOTTOM_X      = 540,
    parameter int BOTTOM_Y      = 400,
    parameter int BAR_WIDTH     = 40,
    parameter int VISIBLE_WIDTH = 25,
    parameter int HEIGHT        = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       frame_tick;
    logic [9:0] x_offset_reg;
    logic       top_on;
    logic       player_on;
    logic       u_on;
    logic       sine_on;
    logic       collision;
    logic       restart;
    logic [1:0] r_next, g_next, b_next;
    logic [1:0] r_reg, g_reg, b_reg;
    logic       hsync_reg, vsync_reg;

    vga_game_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .visible    (visible),
        .frame_tick (frame_tick)
    );

    vga_game_top_line u_top_line (
        .pix_y (vpos),
        .on    (top_on)
    );

    vga_game_player #(
        .PLAYER_X (PLAYER_X),
        .SPEED    (SPEED)
    ) u_player (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .up         (ui_in[0]),
        .down       (ui_in[1]),
        .hold       (collision),
        .restart    (restart),
        .pix_x      (hpos),
        .pix_y      (vpos),
        .on         (player_on)
    );

    vga_game_u_shape u_u_shape (
        .x_offset (x_offset_reg),
        .pix_x    (hpos),
        .pix_y    (vpos),
        .on       (u_on)
    );

    vga_game_double_sine #(
        .TOP_X         (TOP_X),
        .TOP_Y         (TOP_Y),
        .BOTTOM_X      (BOTTOM_X),
        .BOTTOM_Y      (BOTTOM_Y),
        .BAR_WIDTH     (BAR_WIDTH),
        .VISIBLE_WIDTH (VISIBLE_WIDTH),
        .HEIGHT        (HEIGHT)
    ) u_double_sine (
        .x_offset (x_offset_reg),
        .pix_x    (hpos),
        .pix_y    (vpos),
        .on       (sine_on)
    );

`ifdef COLLISION_EN
    logic collision_reg;
    logic unused_inputs;

    assign restart = ui_in[2];

    // Sticky until a restart is seen on a frame tick (never a visible pixel).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            collision_reg <= 1'b0;
        else if (frame_tick && restart)
            collision_reg <= 1'b0;
        else if (visible && player_on && (u_on || sine_on))
            collision_reg <= 1'b1;
    end

    assign collision     = collision_reg;
    assign unused_inputs = &{1'b0, ena, ui_in[7:3], uio_in};
`else
    logic unused_inputs;

    assign restart       = 1'b0;
    assign collision     = 1'b0;
    assign unused_inputs = &{1'b0, ena, ui_in[7:2], uio_in};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            x_offset_reg <= '0;
        else if (frame_tick) begin
            if (restart)
                x_offset_reg <= '0;
            else if (!collision)
                x_offset_reg <= (x_offset_reg == 10'd639) ? 10'd0 : x_offset_reg + 10'd1;
        end
    end

    always_comb begin
        r_next = 2'd0;
        g_next = 2'd0;
        b_next = 2'd0;
        if (visible) begin
            if (player_on) begin
                r_next = 2'd3;
                g_next = collision ? 2'd0 : 2'd3;
            end else if (top_on) begin
                r_next = 2'd3;
                g_next = 2'd3;
                b_next = 2'd3;
            end else if (u_on) begin
                g_next = 2'd3;
            end else if (sine_on) begin
                g_next = 2'd3;
                b_next = 2'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg     <= '0;
            g_reg     <= '0;
            b_reg     <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            r_reg     <= r_next;
            g_reg     <= g_next;
            b_reg     <= b_next;
            hsync_reg <= hsync;
            vsync_reg <= vsync;
        end
    end

    assign uo_out  = {hsync_reg, b_reg[0], g_reg[0], r_reg[0],
                      vsync_reg, b_reg[1], g_reg[1], r_reg[1]};
    assign uio_out = {7'b0, collision};
    assign uio_oe  = 8'h01;
endmodule

// File: tb/tb_tt_um_example_vga_game.sv
// Directed bench for tt_um_example_vga_game (default build): raster timing,
// shape colours at hand-picked pixels, frame-tick scrolling/steering, async reset.
`timescale 1ns/1ps

module tb_tt_um_example_vga_game;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam int FRAME = 800 * 525;
    // uo_out words (syncs high): black, white, yellow, green, cyan
    localparam logic [7:0] C_BLK = 8'h88;
    localparam logic [7:0] C_WHT = 8'hFF;
    localparam logic [7:0] C_YEL = 8'hBB;
    localparam logic [7:0] C_GRN = 8'hAA;
    localparam logic [7:0] C_CYN = 8'hEE;

    // Frame 0: x_offset=0, player y=232.
    localparam int F0_N = 13;
    localparam int F0_X [F0_N] = '{300, 100, 100, 300, 100, 125, 85, 95, 96, 600, 620, 639, 620};
    localparam int F0_Y [F0_N] = '{3, 7, 8, 100, 210, 210, 232, 247, 247, 320, 320, 320, 345};
    localparam logic [7:0] F0_C [F0_N] = '{C_WHT, C_WHT, C_BLK, C_BLK, C_CYN, C_BLK, C_YEL,
                                           C_YEL, C_BLK, C_GRN, C_BLK, C_GRN, C_GRN};

    // Frame 2 (up held through two ticks): x_offset=2, player y=228.
    localparam int F2_N = 12;
    localparam int F2_X [F2_N] = '{137, 138, 85, 85, 85, 85, 597, 598, 637, 638, 138, 138};
    localparam int F2_Y [F2_N] = '{221, 221, 226, 228, 243, 244, 320, 320, 320, 320, 358, 359};
    localparam logic [7:0] F2_C [F2_N] = '{C_BLK, C_CYN, C_BLK, C_YEL, C_YEL, C_BLK,
                                           C_BLK, C_GRN, C_GRN, C_BLK, C_CYN, C_BLK};

    tt_um_example_vga_game dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #20 clk = ~clk;

    // Clock edges since reset release; pixel (x,y) of frame f shows after edge f*FRAME+y*800+x+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #100_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_pix(input int f, input int x, input int y);
        int target;
        target = f * FRAME + y * 800 + x + 1;
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        repeat (5) @(negedge clk);
        checks++;
        if (uo_out !== C_BLK) begin
            failures++;
            $display("FAIL reset_uo_out got=%h exp=%h", uo_out, C_BLK);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uio_out got=%h exp=%h", uio_out, 8'h00);
        end
        checks++;
        if (uio_oe !== 8'h01) begin
            failures++;
            $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, 8'h01);
        end
        $display("reset: uo_out=%h uio_out=%h uio_oe=%h", uo_out, uio_out, uio_oe);
        rst_n = 1'b1;
        // up held, unused ui_in bits and uio_in toggled to show they are ignored
        ui_in  = 8'hF9;
        uio_in = 8'hA5;
    endtask

    task automatic test_frame0_pixels();
        for (int i = 0; i < F0_N; i++) begin
            wait_pix(0, F0_X[i], F0_Y[i]);
            checks++;
            if (uo_out !== F0_C[i]) begin
                failures++;
                $display("FAIL f0_pix(%0d,%0d) got=%h exp=%h", F0_X[i], F0_Y[i], uo_out, F0_C[i]);
            end else
                $display("f0 pixel (%0d,%0d) = %h", F0_X[i], F0_Y[i], uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("FAIL f0_uio_out got=%h exp=%h", uio_out, 8'h00);
        end
    endtask

    task automatic test_sync();
        int hs_err = 0, vs_err = 0, blank_err = 0, bad_lines = 0, vs_low = 0, hs_line = 0;
        for (int idx = FRAME; idx < 2 * FRAME; idx++) begin
            int x, y;
            x = idx % 800;
            y = (idx / 800) % 525;
            while (cyc < idx + 1) @(negedge clk);
            if (x == 0) hs_line = 0;
            if (uo_out[7] == 1'b0) hs_line++;
            if (uo_out[3] == 1'b0) vs_low++;
            if (uo_out[7] !== !(x >= 656 && x < 752)) hs_err++;
            if (uo_out[3] !== !(y == 490 || y == 491)) vs_err++;
            if ((x >= 640 || y >= 480) && (uo_out & 8'h77) != 8'h00) blank_err++;
            if (x == 799 && hs_line != 96) bad_lines++;
        end
        checks++;
        if (hs_err != 0) begin
            failures++;
            $display("FAIL hsync_position got=%0d wrong samples exp=0", hs_err);
        end
        checks++;
        if (bad_lines != 0) begin
            failures++;
            $display("FAIL hsync_width got=%0d lines not 96 clks exp=0", bad_lines);
        end
        checks++;
        if (vs_low != 1600) begin
            failures++;
            $display("FAIL vsync_width got=%0d clks exp=1600", vs_low);
        end
        checks++;
        if (vs_err != 0) begin
            failures++;
            $display("FAIL vsync_position got=%0d wrong samples exp=0", vs_err);
        end
        checks++;
        if (blank_err != 0) begin
            failures++;
            $display("FAIL blank_colour got=%0d lit samples exp=0", blank_err);
        end
        $display("sync frame: hs_err=%0d bad_lines=%0d vs_low=%0d vs_err=%0d blank_err=%0d",
                 hs_err, bad_lines, vs_low, vs_err, blank_err);
    endtask

    task automatic test_scroll_and_move();
        for (int i = 0; i < F2_N; i++) begin
            wait_pix(2, F2_X[i], F2_Y[i]);
            checks++;
            if (uo_out !== F2_C[i]) begin
                failures++;
                $display("FAIL f2_pix(%0d,%0d) got=%h exp=%h", F2_X[i], F2_Y[i], uo_out, F2_C[i]);
            end else
                $display("f2 pixel (%0d,%0d) = %h", F2_X[i], F2_Y[i], uo_out);
        end
    endtask

    task automatic test_async_reset();
        // bar 11 (s=2) lower bar reaches into the window at x=538
        wait_pix(2, 538, 390);
        checks++;
        if (uo_out !== C_CYN) begin
            failures++;
            $display("FAIL f2_pix(538,390) got=%h exp=%h", uo_out, C_CYN);
        end
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== C_BLK) begin
            failures++;
            $display("FAIL async_reset_uo_out got=%h exp=%h", uo_out, C_BLK);
        end
        $display("async reset: uo_out=%h", uo_out);
        ui_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        wait_pix(0, 300, 3);
        checks++;
        if (uo_out !== C_WHT) begin
            failures++;
            $display("FAIL rerun_pix(300,3) got=%h exp=%h", uo_out, C_WHT);
        end
        wait_pix(0, 85, 230);
        checks++;
        if (uo_out !== C_BLK) begin
            failures++;
            $display("FAIL rerun_pix(85,230) got=%h exp=%h", uo_out, C_BLK);
        end
        wait_pix(0, 85, 232);
        checks++;
        if (uo_out !== C_YEL) begin
            failures++;
            $display("FAIL rerun_pix(85,232) got=%h exp=%h", uo_out, C_YEL);
        end
        $display("rerun: player back at y=232, uo_out=%h", uo_out);
    endtask

    initial begin
        test_reset();
        test_frame0_pixels();
        test_sync();
        test_scroll_and_move();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
